// File: rtl/pow2_arb_pkg.sv
// Shared constants and helpers for the pow2 round-robin arbiter.
// Optional grant counters are enabled with POW2_ARB_STATS_EN.
package pow2_arb_pkg;

  localparam int unsigned width_lp       = 32;
  localparam int unsigned stats_width_lp = 16;

  function automatic int unsigned tag_width(
    input int unsigned n
  );
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pow2_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight op.
// Pointers wrap modulo the depth, so any depth >= 2 is supported.
module pow2_tag_fifo
  import pow2_arb_pkg::*;
#(
  parameter int unsigned els_p   = 4,
  parameter int unsigned width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned ptr_w_lp = tag_width(els_p);
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  typedef logic [ptr_w_lp-1:0] ptr_t;
  typedef logic [cnt_w_lp-1:0] cnt_t;

  localparam ptr_t last_lp  = ptr_t'(els_p - 1);
  localparam cnt_t depth_lp = cnt_t'(els_p);

  logic [width_p-1:0] mem_q [els_p];
  ptr_t wr_q, wr_d;
  ptr_t rd_q, rd_d;
  cnt_t cnt_q, cnt_d;
  logic push_ok, pop_ok;

  assign full_o  = (cnt_q == depth_lp);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok)
      wr_d = (wr_q == last_lp) ? '0 : wr_q + 1'b1;
    if (pop_ok)
      rd_d = (rd_q == last_lp) ? '0 : rd_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(els_p); i++)
        mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_ok)
        mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pow2_arbiter.sv
// Round-robin arbiter sharing one pow2 unit among els_p requesters.
// Define POW2_ARB_STATS_EN to add per-requester saturating grant counters.
module pow2_arbiter
  import pow2_arb_pkg::*;
#(
  parameter int unsigned els_p          = 4,
  parameter int unsigned width_p        = width_lp,
  parameter int unsigned tag_fifo_els_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [els_p*width_p-1:0] exp_i,
  input  logic [els_p-1:0]         v_i,
  output logic [els_p-1:0]         ready_o,
  output logic [width_p-1:0]       data_o,
  output logic [els_p-1:0]         v_o,
  input  logic [els_p-1:0]         yumi_i,
  output logic [width_p-1:0]       pow2_exp_o,
  output logic                     pow2_v_o,
  input  logic                     pow2_ready_i,
  input  logic [width_p-1:0]       pow2_data_i,
  input  logic                     pow2_v_i,
  output logic                     pow2_yumi_o
`ifdef POW2_ARB_STATS_EN
  ,
  output logic [els_p*stats_width_lp-1:0] grant_count_o
`endif
);

  localparam int unsigned tag_w_lp = tag_width(els_p);

  typedef logic [tag_w_lp-1:0] tag_t;

  localparam tag_t last_lp = tag_t'(els_p - 1);

  tag_t        rr_q, rr_d;
  tag_t        grant, head, idx;
  int unsigned sum;
  logic        found, any_v, full, empty;
  logic        issue, ret_v;

  assign any_v = |v_i;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      sum = 32'(rr_q) + i;
      idx = tag_t'((sum >= els_p) ? sum - els_p : sum);
      if (!found && v_i[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Reset masks the request side so nothing issues or pushes while flushing.
  assign pow2_v_o = any_v & ~full & ~reset_i;
  assign issue    = pow2_v_o & pow2_ready_i;

  assign pow2_exp_o = (any_v & ~reset_i)
    ? exp_i[grant*width_p +: width_p]
    : '0;

  always_comb begin
    ready_o        = '0;
    ready_o[grant] = issue;
  end

  assign ret_v       = pow2_v_i & ~empty;
  assign pow2_yumi_o = ret_v & yumi_i[head];
  assign data_o      = pow2_data_i;

  always_comb begin
    v_o       = '0;
    v_o[head] = ret_v;
  end

  always_comb begin
    rr_d = rr_q;
    if (issue)
      rr_d = (grant == last_lp) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      rr_q <= '0;
    else
      rr_q <= rr_d;
  end

  pow2_tag_fifo #(
    .els_p   (tag_fifo_els_p),
    .width_p (tag_w_lp)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (issue),
    .data_i  (grant),
    .pop_i   (pow2_yumi_o),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef POW2_ARB_STATS_EN
  typedef logic [stats_width_lp-1:0] cnt_t;

  cnt_t cnt_q [els_p];
  cnt_t cnt_d [els_p];

  always_comb begin
    for (int unsigned i = 0; i < els_p; i++) begin
      cnt_d[i] = cnt_q[i];
      if (issue && grant == tag_t'(i) && cnt_q[i] != '1)
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < els_p; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < els_p; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < int'(els_p); g++) begin : g_cnt
    assign grant_count_o[g*stats_width_lp +: stats_width_lp] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_pow2_arbiter.sv
// Scoreboard bench for pow2_arbiter with a queue-based pow2 model.
// Grants and results are checked by monitors against expected queues.
module tb_pow2_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] exp_i;
  logic [N-1:0]   v_i, ready_o, v_o, yumi_i;
  logic [W-1:0]   data_o, pow2_exp_o, pow2_data_i;
  logic           pow2_v_o, pow2_ready_i, pow2_v_i, pow2_yumi_o;
`ifdef POW2_ARB_STATS_EN
  logic [N*16-1:0] grant_count_o;
`endif

  pow2_arbiter #(
    .els_p          (N),
    .width_p        (W),
    .tag_fifo_els_p (D)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .exp_i        (exp_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .pow2_exp_o   (pow2_exp_o),
    .pow2_v_o     (pow2_v_o),
    .pow2_ready_i (pow2_ready_i),
    .pow2_data_i  (pow2_data_i),
    .pow2_v_i     (pow2_v_i),
    .pow2_yumi_o  (pow2_yumi_o)
`ifdef POW2_ARB_STATS_EN
    ,
    .grant_count_o (grant_count_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] val;
  } ent_t;

  ent_t        preq[$];
  ent_t        gq[$];
  ent_t        rq[$];
  logic [31:0] p_q[$];

  int asserts = 0;
  int fails   = 0;

  logic         stall_p   = 1'b0;
  logic         force_v   = 1'b0;
  logic [N-1:0] yumi_mask = '1;

  logic [N-1:0] s_fire;
  logic         s_iss, s_yum;
  logic [31:0]  s_exp;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    logic [N-1:0]   v;
    logic [N*W-1:0] e;
    v = '0;
    e = '0;
    for (int k = preq.size() - 1; k >= 0; k--) begin
      v[preq[k].id] = 1'b1;
      e[preq[k].id*W +: W] = preq[k].val;
    end
    v_i          = v;
    exp_i        = e;
    yumi_i       = yumi_mask;
    pow2_ready_i = 1'b1;
    pow2_v_i     = force_v | (p_q.size() != 0 && !stall_p);
    if (force_v)
      pow2_data_i = 32'd123;
    else if (p_q.size() != 0)
      pow2_data_i = p_q[0];
    else
      pow2_data_i = 32'hDEAD_BEEF;
  endtask

  task automatic req(int id, logic [31:0] e);
    preq.push_back(ent_t'{id: 2'(id), val: e});
  endtask

  task automatic exp_g(int id, logic [31:0] e);
    gq.push_back(ent_t'{id: 2'(id), val: e});
  endtask

  task automatic exp_r(int id, logic [31:0] r);
    rq.push_back(ent_t'{id: 2'(id), val: r});
  endtask

  // Handshakes are sampled mid-cycle, applied on the next rising edge.
  always @(negedge clk) begin
    s_fire = ready_o;
    s_iss  = pow2_v_o & pow2_ready_i;
    s_yum  = pow2_yumi_o;
    s_exp  = pow2_exp_o;
  end

  always @(posedge clk) begin
    logic done;
    if (rst) begin
      p_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        done = 1'b0;
        if (s_fire[i]) begin
          for (int k = 0; k < preq.size(); k++) begin
            if (!done && preq[k].id == 2'(i)) begin
              preq.delete(k);
              done = 1'b1;
            end
          end
        end
      end
      if (s_yum && p_q.size() != 0)
        void'(p_q.pop_front());
      if (s_iss)
        p_q.push_back(32'd1 << s_exp);
    end
    #1 drive();
  end

  always @(negedge clk) begin
    ent_t e;
    if (!rst) begin
      check("v_o_onehot", 32'($countones(v_o) <= 1), 32'd1);
      if (ready_o != '0) begin
        if (gq.size() == 0) begin
          check("unexpected_grant", 32'(ready_o), 32'd0);
        end else begin
          e = gq.pop_front();
          check("grant_onehot", 32'(ready_o), 32'd1 << e.id);
          check("grant_exp", pow2_exp_o, e.val);
        end
      end
      check("yumi_gate", 32'(pow2_yumi_o), 32'(|(v_o & yumi_i)));
      if (pow2_yumi_o) begin
        if (rq.size() == 0) begin
          check("unexpected_result", 32'(v_o), 32'd0);
        end else begin
          e = rq.pop_front();
          check("result_v_o", 32'(v_o), 32'd1 << e.id);
          check("result_data", data_o, e.val);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    preq.delete();
    drive();
    @(posedge clk);
    #2 rst = 1'b0;
    drive();
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((preq.size() + gq.size() + rq.size() + p_q.size()) != 0
           && n < 200) begin
      @(posedge clk);
      n++;
    end
    check({name, "_done"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_v_o", 32'(v_o), 32'd0);
    check("rst_pow2_v", 32'(pow2_v_o), 32'd0);
    check("rst_pow2_yumi", 32'(pow2_yumi_o), 32'd0);
    check("rst_pow2_exp", pow2_exp_o, 32'd0);
    check("rst_data", data_o, 32'hDEAD_BEEF);
`ifdef POW2_ARB_STATS_EN
    check("rst_cnt_lo", grant_count_o[31:0], 32'd0);
    check("rst_cnt_hi", grant_count_o[63:32], 32'd0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;
    drive();

    // single request
    @(posedge clk);
    #2 req(0, 5);
    exp_g(0, 5);
    exp_r(0, 32);
    drive();
    wait_idle("single");

    // contention, then rr_r must sit at 3
    do_reset();
    req(0, 1);
    req(1, 2);
    req(2, 3);
    exp_g(0, 1); exp_g(1, 2); exp_g(2, 3);
    exp_r(0, 2); exp_r(1, 4); exp_r(2, 8);
    drive();
    wait_idle("contention");
    @(posedge clk);
    #2 req(0, 4);
    req(3, 6);
    exp_g(3, 6); exp_g(0, 4);
    exp_r(3, 64); exp_r(0, 16);
    drive();
    wait_idle("rr_after");

    // fairness
    do_reset();
    for (int i = 0; i < N; i++) req(i, 32'(i + 1));
    for (int i = 0; i < N; i++) req(i, 32'(i + 5));
    for (int i = 0; i < 2 * N; i++) begin
      exp_g(i % N, 32'(i + 1));
      exp_r(i % N, 32'd1 << (i + 1));
    end
    drive();
    wait_idle("fair");

    // head-of-line blocking with a full FIFO
    @(posedge clk);
    #2 yumi_mask = 4'b1101;
    req(1, 3);
    req(2, 4);
    exp_g(1, 3); exp_g(2, 4);
    exp_r(1, 8); exp_r(2, 16);
    drive();
    repeat (5) @(posedge clk);
    #2 req(3, 1);
    exp_g(3, 1);
    exp_r(3, 2);
    drive();
    @(negedge clk);
    check("hol_v_o", 32'(v_o), 32'b0010);
    check("hol_data", data_o, 32'd8);
    check("hol_yumi", 32'(pow2_yumi_o), 32'd0);
    check("full_pow2_v", 32'(pow2_v_o), 32'd0);
    check("full_ready", 32'(ready_o), 32'd0);
    @(posedge clk);
    #2 yumi_mask = '1;
    drive();
    @(negedge clk);
    check("pop_yumi", 32'(pow2_yumi_o), 32'd1);
    check("pop_pow2_v", 32'(pow2_v_o), 32'd0);
    @(negedge clk);
    check("reissue_pow2_v", 32'(pow2_v_o), 32'd1);
    check("reissue_ready", 32'(ready_o), 32'b1000);
    check("hol_next_v_o", 32'(v_o), 32'b0100);
    wait_idle("hol");

    // reset with ops in flight and pow2 stalled
    @(posedge clk);
    #2 stall_p = 1'b1;
    req(0, 2);
    req(1, 3);
    req(3, 4);
    exp_g(0, 2); exp_g(1, 3);
    drive();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stall_pow2_v", 32'(pow2_v_o), 32'd0);
    check("stall_ready", 32'(ready_o), 32'd0);
    check("stall_v_o", 32'(v_o), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    preq.delete();
    stall_p = 1'b0;
    drive();
    @(negedge clk);
    check("mid_rst_v_o", 32'(v_o), 32'd0);
    check("mid_rst_ready", 32'(ready_o), 32'd0);
    check("mid_rst_pow2_v", 32'(pow2_v_o), 32'd0);
`ifdef POW2_ARB_STATS_EN
    check("mid_rst_cnt_lo", grant_count_o[31:0], 32'd0);
    check("mid_rst_cnt_hi", grant_count_o[63:32], 32'd0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;
    force_v = 1'b1;
    drive();
    @(negedge clk);
    check("empty_v_o", 32'(v_o), 32'd0);
    check("empty_yumi", 32'(pow2_yumi_o), 32'd0);
    check("empty_data", data_o, 32'd123);
    @(posedge clk);
    #2 force_v = 1'b0;
    req(2, 7);
    req(0, 9);
    exp_g(0, 9); exp_g(2, 7);
    exp_r(0, 512); exp_r(2, 128);
    drive();
    wait_idle("post_rst");

    repeat (3) @(posedge clk);
    check("gq_empty", 32'(gq.size()), 32'd0);
    check("rq_empty", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule

// File: doc/pow2_arbiter.md
# pow2_arbiter

Round-robin arbiter that shares one `pow2` unit among `els_p` independent requesters. Each requester submits a 32-bit exponent over valid/ready and receives its result over valid/yumi. The block sits between the requester ports and the single `pow2` instance. It records the requester ID of every issued operation in an in-order tag FIFO so that each result returns to the requester that issued it.

## Interface
- `els_p`, 4: number of requesters (≥2).
- `width_p`, 32: exponent and result width.
- `tag_fifo_els_p`, 4: maximum operations in flight inside `pow2` (≥2).
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset.
  - Reset is asynchronous and active-high.
  - There is one clock; `reset_i` is asynchronous, active-high.
- `exp_i`  in  els_p×width_p  per-requester exponent.
- `v_i`  in  els_p  per-requester request valid.
- `ready_o`  out  els_p  per-requester accept; one-hot or zero.
- `data_o`  out  width_p  result, shared by all requesters.
- `v_o`  out  els_p  per-requester result valid; one-hot or zero.
- `yumi_i`  in  els_p  per-requester result consume.
- `pow2_exp_o`  out  width_p  exponent to `pow2`.
- `pow2_v_o`  out  1  request valid to `pow2`.
- `pow2_ready_i`  in  1  `pow2` ready.
- `pow2_data_i`  in  width_p  `pow2` result.
- `pow2_v_i`  in  1  `pow2` result valid.
- `pow2_yumi_o`  out  1  result consume to `pow2`.

## Operation
- **Round-robin pointer `rr_r`** (tag width = max(1, clog2(els_p)); reset 0).
  - Grant goes to the first requester with `v_i` set, searching from `rr_r` upward with wrap-around.
- **Issue condition:** `issue = any(v_i) & pow2_ready_i & ~fifo_full`.
  - `pow2_v_o = any(v_i) & ~fifo_full`.
  - `pow2_exp_o` = exponent of the granted requester.
  - `ready_o[g] = issue`; every other `ready_o` bit is 0.
- **On issue:**
  - Push `g` into the tag FIFO.
  - Set `rr_r <= (g+1) mod els_p`.
  - Hold `rr_r` on cycles with no issue.
- **Return path:**
  - `h` = head tag of the FIFO.
  - `v_o[h] = pow2_v_i & ~fifo_empty`; all other `v_o` bits are 0.
  - `data_o = pow2_data_i`.
  - `pow2_yumi_o = yumi_i[h] & v_o[h]`.
  - Each `pow2_yumi_o` pops the FIFO.
- Results complete strictly in order. A stalled head requester blocks the results of every other requester (head-of-line blocking is intended).
- `yumi_i` on a bit whose `v_o` is low is ignored.
- A push and a pop in the same cycle are legal when the FIFO is not full. Occupancy is then unchanged.
- When the FIFO is full, no issue happens, even if a pop occurs in that cycle.
- `pow2_v_i` while the FIFO is empty is a protocol error. It is ignored, and `pow2_yumi_o` stays 0.
- **Reset mid-operation:**
  - The FIFO is flushed and `rr_r` goes to 0.
  - `pow2` shares `reset_i`, so in-flight results are discarded.

## Timing
- **Reset values:**
  - `ready_o` = 0, `v_o` = 0, `pow2_v_o` = 0, `pow2_yumi_o` = 0, `pow2_exp_o` = 0.
  - `data_o` follows `pow2_data_i`.
- The grant and both handshake paths are combinational, adding zero cycles of latency. End-to-end latency equals the `pow2` latency.
- The FIFO and `rr_r` are the only state. They update on the `clk_i` rising edge.
- Sustained throughput is one issue per cycle while `pow2` accepts and the FIFO is not full.
- Requesters must hold `v_i` and `exp_i` until `ready_o` is seen; they must not retract a request.

## Configuration
- **`POW2_ARB_STATS_EN` defined:** adds output `grant_count_o` (els_p×16), one counter per requester.
  - Each counter is cleared by reset, increments on each issue to its requester, and saturates at 16'hFFFF.
- **Undefined:** the port and the counters are absent, and all other behaviour is identical.

## Structure
- **Shared package `pow2_arb_pkg`:**
  - Default width constant.
  - Stats counter width constant (16).
  - Tag-width helper function.
- **Sub-module `pow2_tag_fifo`:**
  - Synchronous FIFO, `tag_fifo_els_p` deep, with push, pop, head tag, full and empty.
  - Pointers wrap modulo the depth.
  - Async reset.
- The arbiter body holds the round-robin grant, the muxes and the optional counters.

## Test plan
- **Single request:** requester 0 sends exponent 5 with `yumi_i` always high → `v_o` = 4'b0001, `data_o` = 32.
- **Contention:** after reset, requesters 0, 1 and 2 are valid simultaneously with exponents 1, 2, 3 → grant order 0, 1, 2; results 2, 4, 8 on `v_o` bits 0, 1, 2 in that order; `rr_r` ends at 3.
- **Fairness:** all 4 requesters are held valid for 8 issues → grant sequence 0, 1, 2, 3, 0, 1, 2, 3.
- **Head-of-line:** requester 1 holds `yumi_i` low → requester 2's result is not presented until requester 1 yumis.
- **FIFO full:** `tag_fifo_els_p` = 2 and `pow2` results are stalled → after 2 issues, `pow2_v_o` and all `ready_o` bits stay 0; the first pop re-enables issue on the next cycle.
- **Reset mid-operation:** assert reset with 3 operations in flight → all `v_o` are 0, the FIFO is empty, and the next grant goes to requester 0. With `POW2_ARB_STATS_EN`, all counters read 0.
